// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M execute unit.
// Pipelined multiplier plus radix-2 restoring divider on one CDB port.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 5,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [XLEN-1:0]  in_vj,
  input  logic [XLEN-1:0]  in_vk,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [XLEN-1:0]  out_value
);

  localparam int L  = MUL_STAGES - 1;
  localparam int CW = $clog2(XLEN) + 1;
  localparam int PW = 2 * XLEN;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_st_t;

  div_st_t st, st_nx;

  logic [MUL_STAGES-1:0] mul_v;
  logic [TAG_W-1:0]      mul_tag [MUL_STAGES];
  logic [XLEN-1:0]       mul_res [MUL_STAGES];

  logic [XLEN-1:0]  quot, dvs, rem, div_res;
  logic [TAG_W-1:0] div_tag;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r, is_rem, div_rdy;

  logic            out_load, div_out, mul_stall;
  logic            mul_acc, div_acc;
  logic            a_s, b_s, a_neg, b_neg;
  logic            vk_zero, ovf, last;
  logic [PW-1:0]   pa, pb, prod;
  logic [XLEN-1:0] mul_in, sp_res;
  logic [XLEN:0]   rem_sh, diff;
  logic [XLEN-1:0] q_step, r_step;

  // Handshake and arbitration; a finished divide outranks the mul head
  always_comb begin
    out_load  = !out_valid || out_ready;
    div_out   = (st == DONE) && div_rdy;
    mul_stall = mul_v[L] && !(out_load && !div_out);
    in_ready  = rst_n && !flush &&
                (in_funct3[2] ? (st == IDLE) : !mul_stall);
    mul_acc   = in_valid && in_ready && !in_funct3[2];
    div_acc   = in_valid && in_ready && in_funct3[2];
  end

  // Product with per-operand sign extension, high/low half select
  always_comb begin
    a_s    = in_funct3[1:0] != 2'b11;
    b_s    = in_funct3[1:0] == 2'b01;
    pa     = {{XLEN{a_s & in_vj[XLEN-1]}}, in_vj};
    pb     = {{XLEN{b_s & in_vk[XLEN-1]}}, in_vk};
    prod   = pa * pb;
    mul_in = (in_funct3[1:0] == 2'b00) ?
             prod[XLEN-1:0] : prod[PW-1:XLEN];
  end

  // Divider operand prep, special cases and one restoring step
  always_comb begin
    a_neg   = !in_funct3[0] && in_vj[XLEN-1];
    b_neg   = !in_funct3[0] && in_vk[XLEN-1];
    vk_zero = in_vk == '0;
    ovf     = !in_funct3[0] && &in_vk &&
              (in_vj == {1'b1, {(XLEN-1){1'b0}}});
    if (vk_zero)
      sp_res = in_funct3[1] ? in_vj : '1;
    else
      sp_res = in_funct3[1] ? '0 : in_vj;
    rem_sh = {rem, quot[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs};
    q_step = {quot[XLEN-2:0], !diff[XLEN]};
    r_step = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    last   = cnt == CW'(XLEN - 1);
  end

  // Divider next state
  always_comb begin
    st_nx = st;
    if (flush) begin
      st_nx = IDLE;
    end else begin
      unique case (st)
        IDLE: if (div_acc) st_nx = (vk_zero || ovf) ? DONE : BUSY;
        BUSY: if (last) st_nx = DONE;
        DONE: if (div_out && out_load) st_nx = IDLE;
        default: st_nx = IDLE;
      endcase
    end
  end

  // Divider state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  // Divider datapath; the result settles one cycle in DONE before it bids
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot    <= '0;
      dvs     <= '0;
      rem     <= '0;
      div_res <= '0;
      div_tag <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      is_rem  <= 1'b0;
      div_rdy <= 1'b0;
    end else begin
      div_rdy <= (st == DONE) && (st_nx == DONE);
      if (div_acc) begin
        div_tag <= in_tag;
        is_rem  <= in_funct3[1];
        neg_q   <= a_neg ^ b_neg;
        neg_r   <= a_neg;
        quot    <= a_neg ? -in_vj : in_vj;
        dvs     <= b_neg ? -in_vk : in_vk;
        rem     <= '0;
        cnt     <= '0;
        div_res <= sp_res;
      end else if (st == BUSY) begin
        quot <= q_step;
        rem  <= r_step;
        cnt  <= cnt + CW'(1);
        if (last) begin
          if (is_rem) div_res <= neg_r ? -r_step : r_step;
          else        div_res <= neg_q ? -q_step : q_step;
        end
      end
    end
  end

  // Multiplier pipeline, advances as a whole unless the head is blocked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_v <= '0;
      for (int i = 0; i < MUL_STAGES; i++) begin
        mul_tag[i] <= '0;
        mul_res[i] <= '0;
      end
    end else if (flush) begin
      mul_v <= '0;
    end else if (!mul_stall) begin
      mul_v[0]   <= mul_acc;
      mul_tag[0] <= in_tag;
      mul_res[0] <= mul_in;
      for (int i = 1; i < MUL_STAGES; i++) begin
        mul_v[i]   <= mul_v[i-1];
        mul_tag[i] <= mul_tag[i-1];
        mul_res[i] <= mul_res[i-1];
      end
    end
  end

  // Single-entry result register toward the CDB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_value <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (out_load) begin
      if (div_out) begin
        out_valid <= 1'b1;
        out_tag   <= div_tag;
        out_value <= div_res;
      end else if (mul_v[L]) begin
        out_valid <= 1'b1;
        out_tag   <= mul_tag[L];
        out_value <= mul_res[L];
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit.
// Hand-computed vectors, latency, backpressure, flush and async reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_funct3 = 3'd0;
  logic [4:0]  in_tag = 5'd0;
  logic [31:0] in_vj = 32'd0;
  logic [31:0] in_vk = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_tag;
  logic [31:0] out_value;

  int errs = 0;
  int checks = 0;
  int seen;
  int t;
  logic [4:0] acc_q[$];

  muldiv_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_funct3 (in_funct3),
    .in_tag    (in_tag),
    .in_vj     (in_vj),
    .in_vk     (in_vk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .out_value (out_value)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] tg);
    int k;
    k = 0;
    in_funct3 = f;
    in_vj = a;
    in_vk = b;
    in_tag = tg;
    in_valid = 1'b1;
    #1;
    while (!in_ready && k < 100) begin
      step;
      k++;
    end
    chk("accept", {31'd0, in_ready}, 32'd1);
    step;
    in_valid = 1'b0;
  endtask

  task automatic run(input string name,
                     input logic [2:0] f,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [4:0] tg,
                     input logic [31:0] exp,
                     input int lat);
    int k;
    k = 0;
    issue(f, a, b, tg);
    while (!out_valid && k < 60) begin
      step;
      k++;
    end
    chk({name, "_lat"}, k, lat);
    chk({name, "_val"}, out_value, exp);
    chk({name, "_tag"}, {27'd0, out_tag}, {27'd0, tg});
    step;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    in_valid = 1'b1;
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
    chk("rst_out_value", out_value, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    #10 rst_n = 1'b1;
    step;
    step;

    // four back-to-back MULs 7 * -3
    out_ready = 1'b1;
    in_funct3 = 3'd0;
    in_vj = 32'd7;
    in_vk = 32'hFFFF_FFFD;
    in_valid = 1'b1;
    in_tag = 5'd1;
    #1;
    chk("burst_ready", {31'd0, in_ready}, 32'd1);
    step;
    chk("burst_n0", {31'd0, out_valid}, 32'd0);
    in_tag = 5'd2;
    step;
    chk("burst_n1", {31'd0, out_valid}, 32'd0);
    in_tag = 5'd3;
    step;
    chk("burst_t1", {27'd0, out_tag}, 32'd1);
    chk("burst_v1", out_value, 32'hFFFF_FFEB);
    in_tag = 5'd4;
    step;
    in_valid = 1'b0;
    chk("burst_t2", {27'd0, out_tag}, 32'd2);
    chk("burst_v2", out_value, 32'hFFFF_FFEB);
    step;
    chk("burst_t3", {27'd0, out_tag}, 32'd3);
    step;
    chk("burst_t4", {27'd0, out_tag}, 32'd4);
    chk("burst_v4", out_value, 32'hFFFF_FFEB);
    step;
    chk("burst_empty", {31'd0, out_valid}, 32'd0);

    // high-half multiplies
    run("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000,
        5'd5, 32'h4000_0000, 2);
    run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        5'd6, 32'hFFFF_FFFF, 2);
    run("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        5'd7, 32'hFFFF_FFFE, 2);

    // iterative divides
    run("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2,
        5'd8, 32'hFFFF_FFFD, 34);
    run("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2,
        5'd9, 32'hFFFF_FFFF, 34);
    run("divu_100_7", 3'd5, 32'd100, 32'd7,
        5'd10, 32'd14, 34);
    run("remu_100_7", 3'd7, 32'd100, 32'd7,
        5'd11, 32'd2, 34);
    run("div_7_m2", 3'd4, 32'd7, 32'hFFFF_FFFE,
        5'd12, 32'hFFFF_FFFD, 34);
    run("rem_7_m2", 3'd6, 32'd7, 32'hFFFF_FFFE,
        5'd13, 32'd1, 34);

    // special-case divides
    run("div_by0", 3'd4, 32'd5, 32'd0,
        5'd14, 32'hFFFF_FFFF, 2);
    run("remu_by0", 3'd7, 32'd5, 32'd0,
        5'd15, 32'd5, 2);
    run("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
        5'd16, 32'h8000_0000, 2);
    run("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF,
        5'd17, 32'd0, 2);

    // backpressure: DIV then MULs while the CDB is blocked
    out_ready = 1'b0;
    issue(3'd5, 32'd100, 32'd7, 5'd10);
    in_funct3 = 3'd0;
    in_vk = 32'd3;
    in_valid = 1'b1;
    t = 11;
    for (int i = 0; i < 20; i++) begin
      in_tag = t[4:0];
      in_vj = t;
      #0;
      if (in_ready) begin
        acc_q.push_back(t[4:0]);
        t++;
      end
      step;
    end
    chk("bp_mid_tag", {27'd0, out_tag}, 32'd11);
    chk("bp_mid_val", out_value, 32'd33);
    for (int i = 0; i < 20; i++) begin
      in_tag = t[4:0];
      in_vj = t;
      #0;
      if (in_ready) begin
        acc_q.push_back(t[4:0]);
        t++;
      end
      step;
    end
    chk("bp_mul_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    chk("bp_accepted", acc_q.size(), 32'd3);
    chk("bp_end_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_end_tag", {27'd0, out_tag}, 32'd11);
    chk("bp_end_val", out_value, 32'd33);
    in_funct3 = 3'd4;
    #1;
    chk("bp_div_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step;
    chk("bp_r1_tag", {27'd0, out_tag}, 32'd10);
    chk("bp_r1_val", out_value, 32'd14);
    step;
    chk("bp_r2_tag", {27'd0, out_tag}, 32'd12);
    chk("bp_r2_val", out_value, 32'd36);
    step;
    chk("bp_r3_tag", {27'd0, out_tag}, 32'd13);
    chk("bp_r3_val", out_value, 32'd39);
    step;
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // flush during a busy divide with a MUL offered
    issue(3'd5, 32'd100, 32'd7, 5'd20);
    repeat (10) step;
    in_funct3 = 3'd0;
    in_tag = 5'd21;
    in_vj = 32'd1;
    in_vk = 32'd1;
    in_valid = 1'b1;
    flush = 1'b1;
    #1;
    chk("fl_mul_ready", {31'd0, in_ready}, 32'd0);
    step;
    flush = 1'b0;
    in_valid = 1'b0;
    in_funct3 = 3'd4;
    #1;
    chk("fl_div_ready", {31'd0, in_ready}, 32'd1);
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    seen = 0;
    repeat (50) begin
      step;
      if (out_valid) seen++;
    end
    chk("fl_no_result", seen, 32'd0);

    // async reset mid-divide with the mul pipe full
    out_ready = 1'b0;
    issue(3'd4, 32'd1000, 32'd3, 5'd22);
    repeat (5) step;
    issue(3'd0, 32'd2, 32'd2, 5'd23);
    issue(3'd0, 32'd3, 32'd2, 5'd24);
    issue(3'd0, 32'd4, 32'd2, 5'd25);
    chk("ar_pre_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_in_ready", {31'd0, in_ready}, 32'd0);
    #1 rst_n = 1'b1;
    step;
    in_funct3 = 3'd4;
    #1;
    chk("ar_div_idle", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    seen = 0;
    repeat (50) begin
      step;
      if (out_valid) seen++;
    end
    chk("ar_no_stale", seen, 32'd0);
    run("recover", 3'd3, 32'hFFFF_FFFF, 32'd2,
        5'd26, 32'd1, 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised M-extension execute unit. Successor to the combinational mul/div path in the execute stage.
- Sits behind the reservation station and drives one common-data-bus result port.
- MUL-class ops go through a pipelined multiplier (MUL_STAGES deep). DIV/REM ops use an iterative radix-2 divider FSM.
- Every result carries its reservation-station tag, so mul and div results may complete out of order.

Parameters:
XLEN, 32, operand/result width (>=8, even)
TAG_W, 5, width of reservation/ROB tag
MUL_STAGES, 2, multiplier latency in cycles (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  kill every op in flight (mispredict)
in_valid  input  1  operation offered
in_ready  output  1  operation accepted when in_valid & in_ready at clk edge
in_funct3  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
in_tag  input  TAG_W  destination tag
in_vj  input  XLEN  rs1 value
in_vk  input  XLEN  rs2 value
out_valid  output  1  result register holds a result
out_ready  input  1  CDB consumes result when out_valid & out_ready
out_tag  output  TAG_W  tag of result
out_value  output  XLEN  result

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_tag=0, out_value=0, all mul stage valids=0, divider FSM=IDLE. in_ready is 0 while rst_n=0.
- Output register: a single entry.
  - Loads when empty or being consumed in the same cycle.
  - out_tag and out_value are held stable while out_valid & !out_ready.
- Multiplier:
  - MUL_STAGES valid/tag/partial registers.
  - Product is 2*XLEN wide. Signedness per funct3: MULH s×s, MULHSU s×u, MULHU u×u.
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
  - Pipeline advances as a whole. It stalls when its last stage is valid and cannot write the output register.
- Divider FSM states IDLE, BUSY, DONE:
  - IDLE->BUSY on an accepted div op. Operands are converted to magnitudes; sign flags and tag are latched.
  - BUSY runs exactly XLEN restoring iterations, one per cycle, then goes to DONE. The quotient/remainder sign fix-up is applied on entry to DONE.
  - Divide by zero: IDLE->DONE directly. DIV/DIVU give all-ones; REM/REMU give the dividend.
  - Signed overflow (DIV/REM, vj=most-negative, vk=-1): IDLE->DONE directly. DIV gives vj; REM gives 0.
  - DONE->IDLE when the result is written to the output register.
- Output arbitration: when the divider is in DONE and the mul last stage is valid in the same cycle, the divider wins and the mul pipeline stalls one cycle.
- in_ready:
  - For funct3[2]=0: equals !mul_stall.
  - For funct3[2]=1: equals (FSM==IDLE).
  - Forced to 0 when flush=1.
  - in_ready is combinational from in_funct3 and state only; it never depends on in_valid.
- Latency with no backpressure:
  - Mul accepted at edge N gives out_valid high after edge N+MUL_STAGES.
  - Normal div gives out_valid after edge N+XLEN+2.
  - Special-case div gives out_valid after edge N+2.
- Mul throughput is 1 op/cycle. Divider has one op in flight; muls continue to issue while the divider is BUSY.
- flush (synchronous, takes effect at the next edge):
  - Clears out_valid and all mul stage valids; FSM goes to IDLE.
  - Any input offered during the flush cycle is not accepted.
  - A result presented on out_valid during the flush cycle counts as consumed only if out_ready=1.
- rst_n asserted mid-operation: immediate clear regardless of clock; no partial result is ever emitted.

Test Plan:
- MUL vj=7, vk=-3 in 4 consecutive cycles with out_ready=1 -> four results 0xFFFFFFEB, one per cycle, first after edge N+2, tags in issue order.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHSU -1×0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- DIV -7/2 -> -3, REM -7/2 -> -1, DIVU 100/7 -> 14, each with out_valid exactly 34 cycles after accept. DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5 after 2 cycles. DIV 0x80000000/-1 -> 0x80000000 and REM -> 0.
- Issue DIV, then MULs every cycle while out_ready=0 for 40 cycles -> out_value/out_tag frozen, in_ready drops for MUL once the pipe is full. Release -> every result appears once, div result before the stalled mul head.
- DIV in BUSY at iteration 10, pulse flush with an in_valid MUL present -> that MUL is not accepted, no div result ever appears, in_ready for div is 1 next cycle.
- Drop rst_n for a partial cycle during BUSY with mul stages full -> out_valid=0 immediately, FSM=IDLE, no stale result after release.
